// File: rtl/add_pkg.sv
// Shared constants, stage-register record and carry helper for the 64-bit pipelined adder.
package add_pkg;

    localparam int unsigned SLICE_W = 16;
    localparam int unsigned NSLICE  = 4;
    localparam int unsigned DATA_W  = 64;

    // One pipeline stage: operands still to be added, sum slices already done, slice carry-out
    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [DATA_W-1:0] s;
        logic              c;
    } stage_t;

    function automatic logic slice_carry(input logic g, input logic p, input logic c);
        return g | (p & c);
    endfunction

endpackage

// File: rtl/pipe_add64_if.sv
// Operand/result handshake bundle for pipe_add64.
interface pipe_add64_if;
    import add_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic              cin;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] sum;
    logic              cout;

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout
    );

endinterface

// File: rtl/CLA_16bits.sv
// 16-bit carry-lookahead slice: four 4-bit groups with lookahead between groups.
module CLA_16bits (
    input  logic [15:0] A,
    input  logic [15:0] B,
    input  logic        Cin,
    output logic [15:0] R,
    output logic        P,
    output logic        G
);

    logic [15:0] bg;
    logic [15:0] bp;
    logic [3:0]  gg;
    logic [3:0]  gp;
    logic [3:0]  gc;

    assign bg = A & B;
    assign bp = A ^ B;

    // group generate/propagate
    always_comb begin
        gg = '0;
        gp = '0;
        for (int i = 0; i < 4; i++) begin
            gp[i] = &bp[4*i +: 4];
            gg[i] = bg[4*i+3]
                  | (bp[4*i+3] & bg[4*i+2])
                  | (bp[4*i+3] & bp[4*i+2] & bg[4*i+1])
                  | ((&bp[4*i+1 +: 3]) & bg[4*i]);
        end
    end

    assign gc[0] = Cin;
    assign gc[1] = gg[0] | (gp[0] & Cin);
    assign gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & Cin);
    assign gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
                 | (gp[2] & gp[1] & gp[0] & Cin);

    assign P = &gp;
    assign G = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
             | (gp[3] & gp[2] & gp[1] & gg[0]);

    // short ripple inside each group, seeded by the lookahead carry
    always_comb begin
        logic [15:0] c;
        c = '0;
        for (int i = 0; i < 16; i++) begin
            if ((i % 4) == 0) begin
                c[i] = gc[i/4];
            end else begin
                c[i] = bg[i-1] | (bp[i-1] & c[i-1]);
            end
        end
        R = bp ^ c;
    end

endmodule

// File: rtl/pipe_add64.sv
// 64-bit adder pipelined as four 16-bit CLA slices with registered inter-slice carries and a global stall.
module pipe_add64
    import add_pkg::*;
#(
    parameter int unsigned SLICE_W = add_pkg::SLICE_W,
    parameter int unsigned NSLICE  = add_pkg::NSLICE
) (
    input  logic         clk,
    input  logic         rst,
    pipe_add64_if.slave  bus
);

    if (SLICE_W != 16 || SLICE_W * NSLICE != DATA_W) begin : g_bad_cfg
        $error("pipe_add64 supports only SLICE_W=16, NSLICE=4");
    end

    stage_t             st  [NSLICE];
    stage_t             nxt [NSLICE];
    logic [SLICE_W-1:0] op_a [NSLICE];
    logic [SLICE_W-1:0] op_b [NSLICE];
    logic [SLICE_W-1:0] r    [NSLICE];
    logic [NSLICE-1:0]  c_in;
    logic [NSLICE-1:0]  p;
    logic [NSLICE-1:0]  g;
    logic               stall;

    assign stall        = st[NSLICE-1].valid && !bus.out_ready;
    assign bus.in_ready = !stall;

    // slice k reads from stage k-1; only slice 0 sees the external operands and cin
    for (genvar k = 0; k < NSLICE; k++) begin : g_slice
        if (k == 0) begin : g_head
            assign op_a[k] = bus.a[k*SLICE_W +: SLICE_W];
            assign op_b[k] = bus.b[k*SLICE_W +: SLICE_W];
            assign c_in[k] = bus.cin;
        end else begin : g_tail
            assign op_a[k] = st[k-1].a[k*SLICE_W +: SLICE_W];
            assign op_b[k] = st[k-1].b[k*SLICE_W +: SLICE_W];
            assign c_in[k] = st[k-1].c;
        end

        CLA_16bits u_cla (
            .A   (op_a[k]),
            .B   (op_b[k]),
            .Cin (c_in[k]),
            .R   (r[k]),
            .P   (p[k]),
            .G   (g[k])
        );
    end

    // next contents of every stage; bubbles move along like real entries
    always_comb begin
        nxt[0]                = '0;
        nxt[0].valid          = bus.in_valid;
        nxt[0].a              = bus.a;
        nxt[0].b              = bus.b;
        nxt[0].s[SLICE_W-1:0] = r[0];
        nxt[0].c              = slice_carry(g[0], p[0], c_in[0]);
        for (int unsigned k = 1; k < NSLICE; k++) begin
            nxt[k]                         = st[k-1];
            nxt[k].s[k*SLICE_W +: SLICE_W] = r[k];
            nxt[k].c                       = slice_carry(g[k], p[k], c_in[k]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned k = 0; k < NSLICE; k++) begin
                st[k] <= '0;
            end
        end else if (!stall) begin
            for (int unsigned k = 0; k < NSLICE; k++) begin
                st[k] <= nxt[k];
            end
        end
    end

    assign bus.out_valid = st[NSLICE-1].valid;
    assign bus.sum       = st[NSLICE-1].s;
    assign bus.cout      = st[NSLICE-1].c;

endmodule

// File: tb/tb_pipe_add64.sv
// Directed and randomized checks of pipe_add64 against hand values and a 65-bit reference sum.
module tb_pipe_add64;
    import add_pkg::*;

    typedef struct packed {
        logic [63:0] a;
        logic [63:0] b;
        logic        cin;
        logic [64:0] e;
    } op_t;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    int   n_out;
    logic prev_stall;
    logic [64:0] prev_d;
    op_t  send_q[$];
    logic [64:0] exp_q[$];

    pipe_add64_if bus ();

    pipe_add64 #(.SLICE_W(16), .NSLICE(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [64:0] got, input logic [64:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
        bus.a        = '0;
        bus.b        = '0;
        bus.cin      = 1'b0;
    endtask

    function automatic logic [64:0] ref_add(input logic [63:0] a, input logic [63:0] b, input logic c);
        return {1'b0, a} + {1'b0, b} + 65'(c);
    endfunction

    // one isolated op: no result for cycles 1..3, result in cycle 4
    task automatic run_one(input string tag, input logic [63:0] a, input logic [63:0] b,
                           input logic cin, input logic [64:0] exp);
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.a         = a;
        bus.b         = b;
        bus.cin       = cin;
        step();
        idle();
        for (int i = 1; i < 4; i++) begin
            chk({tag, "_lat"}, 65'(bus.out_valid), 65'd0);
            step();
        end
        chk({tag, "_v"}, 65'(bus.out_valid), 65'd1);
        chk({tag, "_res"}, {bus.cout, bus.sum}, exp);
        step();
    endtask

    // one handshake cycle driven from send_q, results scored against exp_q
    task automatic cycle(input string tag, input logic allow_in, input logic rdy);
        bus.out_ready = rdy;
        if (allow_in && send_q.size() > 0) begin
            bus.in_valid = 1'b1;
            bus.a        = send_q[0].a;
            bus.b        = send_q[0].b;
            bus.cin      = send_q[0].cin;
        end else begin
            idle();
        end
        #1;
        if (prev_stall) begin
            chk({tag, "_hold_v"}, 65'(bus.out_valid), 65'd1);
            chk({tag, "_hold_d"}, {bus.cout, bus.sum}, prev_d);
        end
        chk({tag, "_in_ready"}, 65'(bus.in_ready), 65'(!(bus.out_valid && !bus.out_ready)));
        if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                chk({tag, "_spurious"}, 65'(bus.out_valid), 65'd0);
            end else begin
                chk(tag, {bus.cout, bus.sum}, exp_q.pop_front());
                n_out++;
            end
        end
        if (bus.in_valid && bus.in_ready) begin
            exp_q.push_back(send_q[0].e);
            void'(send_q.pop_front());
        end
        prev_stall = bus.out_valid && !bus.out_ready;
        prev_d     = {bus.cout, bus.sum};
        step();
    endtask

    initial begin
        op_t o;
        total      = 0;
        bad        = 0;
        n_out      = 0;
        prev_stall = 1'b0;
        prev_d     = '0;
        rst        = 1'b1;
        bus.out_ready = 1'b0;
        idle();
        step();
        step();
        rst = 1'b0;
        #1;
        chk("rst_out_valid", 65'(bus.out_valid), 65'd0);
        chk("rst_result", {bus.cout, bus.sum}, 65'd0);
        chk("rst_in_ready", 65'(bus.in_ready), 65'd1);

        run_one("all_ones_cin", 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, {1'b1, 64'h0});
        run_one("one_boundary", 64'h0000_FFFF_0000_FFFF, 64'h1, 1'b0, {1'b0, 64'h0000_FFFF_0001_0000});
        run_one("msb_overflow", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, {1'b1, 64'h0});
        run_one("mixed", 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0,
                {1'b0, 64'h2222_2222_2222_2211});

        // back-to-back stream, results on cycles 4..7
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = 1'b1;
            bus.a        = 64'(i + 1);
            bus.b        = 64'(i + 1);
            bus.cin      = 1'b0;
            step();
        end
        idle();
        for (int i = 0; i < 4; i++) begin
            chk("stream_v", 65'(bus.out_valid), 65'd1);
            chk("stream_sum", {bus.cout, bus.sum}, 65'(2 * (i + 1)));
            step();
        end
        chk("stream_drain", 65'(bus.out_valid), 65'd0);

        // five ops offered while the consumer stalls cycles 4..6
        send_q.push_back('{a: 64'h0000_0000_0000_FFFF, b: 64'h1, cin: 1'b0, e: 65'h0_0000_0000_0001_0000});
        send_q.push_back('{a: 64'hFFFF_FFFF_FFFF_FFFF, b: 64'h1, cin: 1'b0, e: 65'h1_0000_0000_0000_0000});
        send_q.push_back('{a: 64'h0000_0000_FFFF_FFFF, b: 64'h0, cin: 1'b1, e: 65'h0_0000_0001_0000_0000});
        send_q.push_back('{a: 64'h5, b: 64'h7, cin: 1'b1, e: 65'hD});
        send_q.push_back('{a: 64'h7FFF_FFFF_FFFF_FFFF, b: 64'h1, cin: 1'b0, e: 65'h0_8000_0000_0000_0000});
        n_out = 0;
        bus.out_ready = 1'b0;
        for (int cyc = 0; cyc < 40 && n_out < 5; cyc++) begin
            if (cyc >= 4 && cyc <= 6) begin
                chk("stall_in_ready", 65'(bus.in_ready), 65'd0);
                chk("stall_v", 65'(bus.out_valid), 65'd1);
                chk("stall_frozen", {bus.cout, bus.sum}, 65'h0_0000_0000_0001_0000);
            end
            cycle("stall", 1'b1, cyc >= 7);
        end
        chk("stall_count", 65'(n_out), 65'd5);
        idle();

        // reset with three ops in flight
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1;
            bus.a        = 64'(i + 1);
            bus.b        = 64'h0;
            step();
        end
        idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_v", 65'(bus.out_valid), 65'd0);
        chk("midrst_result", {bus.cout, bus.sum}, 65'd0);
        chk("midrst_in_ready", 65'(bus.in_ready), 65'd1);
        for (int i = 0; i < 6; i++) begin
            step();
            chk("midrst_stale", 65'(bus.out_valid), 65'd0);
        end

        // random traffic against the 65-bit reference
        send_q.delete();
        exp_q.delete();
        n_out      = 0;
        prev_stall = 1'b0;
        for (int i = 0; i < 10000; i++) begin
            o.a   = {$urandom, $urandom};
            o.b   = ($urandom_range(0, 3) == 0) ? ~o.a : {$urandom, $urandom};
            o.cin = 1'($urandom_range(0, 1));
            o.e   = ref_add(o.a, o.b, o.cin);
            send_q.push_back(o);
        end
        for (int cyc = 0; cyc < 60000 && n_out < 10000; cyc++) begin
            cycle("rand", $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7);
        end
        chk("rand_count", 65'(n_out), 65'd10000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
